// File: rtl/rpn_stack_engine.sv
// RPN calculator core: key decode, digit entry, operand stack, and an iterative
// double-dabble converter that produces the four BCD characters for the display.
module rpn_stack_engine #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        key_valid_i,
  input  logic [4:0]  key_code_i,
  output logic        key_ready_o,
  output logic [15:0] numbers_o,
  output logic        err_o,
  output logic [3:0]  depth_o
);

  localparam int unsigned IdxW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned Slots = 1 << IdxW;
  localparam logic [3:0]  DepthMax = 4'(DEPTH);
  localparam logic [13:0] ValMax   = 14'd9999;

  localparam logic [4:0] KeyEnter = 5'h10;
  localparam logic [4:0] KeyAdd   = 5'h11;
  localparam logic [4:0] KeySub   = 5'h12;
  localparam logic [4:0] KeyMul   = 5'h13;
  localparam logic [4:0] KeyClear = 5'h14;
  localparam logic [4:0] KeyDrop  = 5'h15;

  typedef enum logic [1:0] {StIdle, StExec, StConv} state_e;

  state_e      state_q;
  logic [4:0]  code_q;
  logic [13:0] entry_q, entry_d;
  logic        ent_act_q, ent_act_d;
  logic        err_q, err_d;
  logic [3:0]  depth_q, depth_d;
  logic [13:0] bin_q;
  logic [15:0] bcd_q;
  logic [3:0]  cnt_q;
  logic [15:0] numbers_q;
  logic [13:0] stack_q [Slots];

  logic [IdxW-1:0] top_idx, sec_idx, wr_idx, disp_idx;
  logic [13:0]     top_val, sec_val, op_a, op_b, op_res, wr_data, disp_val;
  logic [14:0]     sum;
  logic [27:0]     prod;
  logic            op_ovf, wr_en;
  logic [4:0]      eff_depth;
  logic [15:0]     bcd_adj, bcd_shift;

  // Arithmetic datapath: entry acts as the top operand while digit entry is active.
  always_comb begin
    top_idx = IdxW'(depth_q - 4'd1);
    sec_idx = IdxW'(depth_q - 4'd2);
    top_val = stack_q[top_idx];
    sec_val = stack_q[sec_idx];
    op_b    = ent_act_q ? entry_q : top_val;
    op_a    = ent_act_q ? top_val : sec_val;
    sum     = {1'b0, op_a} + {1'b0, op_b};
    prod    = {14'd0, op_a} * {14'd0, op_b};
    op_res  = '0;
    op_ovf  = 1'b0;
    case (code_q)
      KeyAdd: begin
        if (sum > {1'b0, ValMax}) begin
          op_res = ValMax;
          op_ovf = 1'b1;
        end else begin
          op_res = sum[13:0];
        end
      end
      KeySub: begin
        if (op_a < op_b) begin
          op_res = '0;
          op_ovf = 1'b1;
        end else begin
          op_res = op_a - op_b;
        end
      end
      default: begin
        if (prod > {14'd0, ValMax}) begin
          op_res = ValMax;
          op_ovf = 1'b1;
        end else begin
          op_res = prod[13:0];
        end
      end
    endcase
  end

  // Next architectural state for the key latched in code_q, plus the value to display.
  always_comb begin
    entry_d   = entry_q;
    ent_act_d = ent_act_q;
    err_d     = err_q;
    depth_d   = depth_q;
    wr_en     = 1'b0;
    wr_idx    = top_idx;
    wr_data   = op_res;
    eff_depth = {1'b0, depth_q} + {4'd0, ent_act_q};
    if (code_q <= 5'd9) begin
      if (!ent_act_q) begin
        entry_d   = {10'd0, code_q[3:0]};
        ent_act_d = 1'b1;
      end else if (entry_q < 14'd1000) begin
        entry_d = 14'(entry_q * 14'd10) + {10'd0, code_q[3:0]};
      end
    end else begin
      case (code_q)
        KeyEnter: begin
          if (depth_q == DepthMax) begin
            err_d = 1'b1;
          end else begin
            wr_en     = 1'b1;
            wr_idx    = IdxW'(depth_q);
            wr_data   = ent_act_q ? entry_q : 14'd0;
            depth_d   = depth_q + 4'd1;
            ent_act_d = 1'b0;
          end
        end
        KeyAdd, KeySub, KeyMul: begin
          if (eff_depth < 5'd2) begin
            err_d = 1'b1;
          end else begin
            wr_en     = 1'b1;
            wr_data   = op_res;
            ent_act_d = 1'b0;
            // With an active entry the implicit push and the pop cancel out.
            if (ent_act_q) begin
              wr_idx = top_idx;
            end else begin
              wr_idx  = sec_idx;
              depth_d = depth_q - 4'd1;
            end
            if (op_ovf) err_d = 1'b1;
          end
        end
        KeyClear: begin
          depth_d   = '0;
          entry_d   = '0;
          ent_act_d = 1'b0;
          err_d     = 1'b0;
        end
        KeyDrop: begin
          if (ent_act_q) begin
            ent_act_d = 1'b0;
            entry_d   = '0;
          end else if (depth_q != 4'd0) begin
            depth_d = depth_q - 4'd1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    disp_idx = IdxW'(depth_d - 4'd1);
    if (ent_act_d) begin
      disp_val = entry_d;
    end else if (depth_d == 4'd0) begin
      disp_val = '0;
    end else if (wr_en && (wr_idx == disp_idx)) begin
      disp_val = wr_data;
    end else begin
      disp_val = stack_q[disp_idx];
    end
  end

  // One double-dabble step: add 3 to each nibble >= 5, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_shift = {bcd_adj[14:0], bin_q[13]};
  end

  // Control FSM with registered state, flags and display output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      code_q    <= '0;
      entry_q   <= '0;
      ent_act_q <= 1'b0;
      err_q     <= 1'b0;
      depth_q   <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      numbers_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (key_valid_i) begin
            code_q  <= key_code_i;
            state_q <= StExec;
          end
        end
        StExec: begin
          entry_q   <= entry_d;
          ent_act_q <= ent_act_d;
          err_q     <= err_d;
          depth_q   <= depth_d;
          bin_q     <= disp_val;
          bcd_q     <= '0;
          cnt_q     <= '0;
          state_q   <= StConv;
        end
        StConv: begin
          bcd_q <= bcd_shift;
          bin_q <= {bin_q[12:0], 1'b0};
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd13) begin
            // Thousands go to the leftmost character, i.e. the lowest nibble.
            numbers_q <= {bcd_shift[3:0], bcd_shift[7:4], bcd_shift[11:8], bcd_shift[15:12]};
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stack storage; contents are don't-care after reset so no reset branch.
  always_ff @(posedge clk_i) begin
    if ((state_q == StExec) && wr_en) stack_q[wr_idx] <= wr_data;
  end

  assign key_ready_o = (state_q == StIdle);
  assign numbers_o   = numbers_q;
  assign err_o       = err_q;
  assign depth_o     = depth_q;

endmodule

// File: tb/tb_rpn_stack_engine.sv
// Scoreboard bench for rpn_stack_engine: a behavioural RPN model predicts each key's
// display/depth/err, which is queued on acceptance and compared on completion.
module tb_rpn_stack_engine;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [4:0]  key_code = '0;
  logic        key_ready;
  logic [15:0] numbers;
  logic        err;
  logic [3:0]  depth;

  rpn_stack_engine #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .key_valid_i (key_valid),
    .key_code_i  (key_code),
    .key_ready_o (key_ready),
    .numbers_o   (numbers),
    .err_o       (err),
    .depth_o     (depth)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] num;
    logic [3:0]  dep;
    logic        er;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_stk[$];
  int   m_entry = 0;
  bit   m_act = 1'b0;
  bit   m_err = 1'b0;
  bit   busy = 1'b0;
  int   lat = 0;
  int   accepts = 0;
  logic [15:0] held_exp = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v / 1000);
    r[7:4]   = 4'((v / 100) % 10);
    r[11:8]  = 4'((v / 10) % 10);
    r[15:12] = 4'(v % 10);
    return r;
  endfunction

  function automatic int m_disp();
    if (m_act) return m_entry;
    if (m_stk.size() > 0) return m_stk[$];
    return 0;
  endfunction

  function automatic void m_reset();
    m_stk.delete();
    m_entry = 0;
    m_act = 1'b0;
    m_err = 1'b0;
  endfunction

  function automatic void model_apply(input logic [4:0] c);
    int a, b, r, eff;
    if (c <= 5'd9) begin
      if (!m_act) begin
        m_entry = int'(c);
        m_act = 1'b1;
      end else if (m_entry < 1000) begin
        m_entry = m_entry * 10 + int'(c);
      end
    end else begin
      case (c)
        5'h10: begin
          if (m_stk.size() == DEPTH) m_err = 1'b1;
          else begin
            m_stk.push_back(m_act ? m_entry : 0);
            m_act = 1'b0;
          end
        end
        5'h11, 5'h12, 5'h13: begin
          eff = m_stk.size() + (m_act ? 1 : 0);
          if (eff < 2) m_err = 1'b1;
          else begin
            if (m_act) b = m_entry;
            else b = m_stk.pop_back();
            a = m_stk.pop_back();
            if (c == 5'h11) r = a + b;
            else if (c == 5'h12) r = a - b;
            else r = a * b;
            if (r > 9999) begin r = 9999; m_err = 1'b1; end
            if (r < 0) begin r = 0; m_err = 1'b1; end
            m_stk.push_back(r);
            m_act = 1'b0;
          end
        end
        5'h14: begin m_reset(); end
        5'h15: begin
          if (m_act) m_act = 1'b0;
          else if (m_stk.size() > 0) void'(m_stk.pop_back());
          else m_err = 1'b1;
        end
        default: ;
      endcase
    end
  endfunction

  // One clock: drive at negedge, sample at the following negedge.
  task automatic tick(input logic v, input logic [4:0] c);
    exp_t e;
    key_valid = v;
    key_code  = c;
    if (v && key_ready) begin
      held_exp = to_bcd(m_disp());
      model_apply(c);
      e.num = to_bcd(m_disp());
      e.dep = 4'(m_stk.size());
      e.er  = m_err;
      sb.push_back(e);
      busy = 1'b1;
      lat = 0;
      accepts++;
    end
    @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    if (busy) begin
      lat++;
      if (lat == 2) begin
        check_eq("depth_t2", 32'(depth), 32'(sb[0].dep));
        check_eq("err_t2", 32'(err), 32'(sb[0].er));
      end
      if (lat == 5) check_eq("numbers_held", 32'(numbers), 32'(held_exp));
      if (key_ready) begin
        e = sb.pop_front();
        check_eq("latency", 32'(lat), 32'd16);
        check_eq("numbers", 32'(numbers), 32'(e.num));
        check_eq("depth", 32'(depth), 32'(e.dep));
        check_eq("err", 32'(err), 32'(e.er));
        busy = 1'b0;
      end else if (lat > 40) begin
        check_eq("done_timeout", 32'(key_ready), 32'd1);
        busy = 1'b0;
        void'(sb.pop_front());
      end
    end
  endtask

  task automatic send_key(input logic [4:0] c);
    for (int i = 0; i < 40 && !key_ready; i++) tick(1'b0, 5'd0);
    if (!key_ready) check_eq("ready_timeout", 32'(key_ready), 32'd1);
    tick(1'b1, c);
    for (int i = 0; i < 45 && busy; i++) tick(1'b0, 5'd0);
  endtask

  task automatic send_num(input int v);
    int d[4];
    int n = 0;
    int t = v;
    do begin
      d[n] = t % 10;
      t = t / 10;
      n++;
    end while (t > 0 && n < 4);
    for (int i = n - 1; i >= 0; i--) send_key(5'(d[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_numbers", 32'(numbers), 32'h0);
    check_eq("rst_ready", 32'(key_ready), 32'd1);
    check_eq("rst_depth", 32'(depth), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);

    // Digit entry and the four-digit limit.
    send_num(1234);
    check_eq("entry_1234", 32'(numbers), 32'h4321);
    check_eq("entry_depth0", 32'(depth), 32'd0);
    send_key(5'd5);
    check_eq("entry_limit", 32'(numbers), 32'h4321);
    check_eq("entry_limit_err", 32'(err), 32'd0);

    // Subtraction and underflow clamp.
    send_key(5'h14);
    send_key(5'd7); send_key(5'h10); send_key(5'd5); send_key(5'h12);
    check_eq("sub_7_5", 32'(numbers), 32'h2000);
    check_eq("sub_depth", 32'(depth), 32'd1);
    send_key(5'd9); send_key(5'h12);
    check_eq("sub_under", 32'(numbers), 32'h0000);
    check_eq("sub_under_err", 32'(err), 32'd1);
    send_key(5'h14);
    check_eq("clear_err", 32'(err), 32'd0);
    check_eq("clear_depth", 32'(depth), 32'd0);

    // Multiplication, overflow clamp and a wide in-range product.
    send_num(9999); send_key(5'h10); send_key(5'd2); send_key(5'h13);
    check_eq("mul_clamp", 32'(numbers), 32'h9999);
    check_eq("mul_clamp_err", 32'(err), 32'd1);
    send_key(5'h14);
    send_num(100); send_key(5'h10); send_num(99); send_key(5'h13);
    check_eq("mul_9900", 32'(numbers), 32'h0099);
    check_eq("mul_depth", 32'(depth), 32'd1);

    // Fill the stack, overflow it, then implicit push into a full stack.
    send_key(5'h14);
    for (int i = 0; i < DEPTH; i++) begin
      send_key(5'(i + 1));
      send_key(5'h10);
    end
    send_key(5'h10);
    check_eq("full_err", 32'(err), 32'd1);
    check_eq("full_depth", 32'(depth), 32'(DEPTH));
    send_key(5'd3); send_key(5'h11);
    check_eq("full_add_depth", 32'(depth), 32'(DEPTH));

    // Arithmetic with too few operands leaves the stack intact.
    send_key(5'h14);
    send_key(5'd4); send_key(5'h10); send_key(5'h11);
    check_eq("add_short_err", 32'(err), 32'd1);
    check_eq("add_short_depth", 32'(depth), 32'd1);
    check_eq("add_short_top", 32'(numbers), 32'h4000);

    // DROP variants, unknown code, and an add with entry.
    send_key(5'd6); send_key(5'h15); send_key(5'h15); send_key(5'h15);
    check_eq("drop_empty_depth", 32'(depth), 32'd0);
    send_key(5'h14);
    send_key(5'd2); send_key(5'h1f); send_key(5'h10); send_key(5'd8); send_key(5'h11);
    check_eq("add_2_8", 32'(numbers), 32'h0100);

    // Continuous strobing: only keys seen while ready are taken.
    send_key(5'h14);
    accepts = 0;
    for (int i = 0; i < 48; i++) tick(1'b1, 5'd1);
    check_eq("strobe_accepts", 32'(accepts), 32'd3);
    check_eq("strobe_value", 32'(numbers), 32'h1110);

    // Asynchronous reset while converting.
    send_key(5'h10);
    tick(1'b1, 5'd5);
    for (int i = 0; i < 3; i++) tick(1'b0, 5'd0);
    rst = 1'b1;
    #1;
    check_eq("rst_conv_numbers", 32'(numbers), 32'h0);
    check_eq("rst_conv_ready", 32'(key_ready), 32'd1);
    check_eq("rst_conv_depth", 32'(depth), 32'd0);
    sb.delete();
    busy = 1'b0;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_key(5'd8);
    check_eq("after_rst_8", 32'(numbers), 32'h8000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rpn_stack_engine.md
# rpn_stack_engine

Arithmetic core of the VGA stack calculator: accepts key codes, maintains digit entry and an RPN operand stack, executes ADD/SUB/MUL/DROP/CLEAR, and converts the displayed value to four BCD digits with an iterative double-dabble. Its `numbers` output drives the `numbers[15:0]` input of the picture generator directly, one character per nibble.

## Interface
- `DEPTH`, 8: operand stack entries (2..15)
- `clk`  in  1  system clock, shared with VGA pipeline
- `rst`  in  1  reset, asynchronous, active-high
- `key_valid`  in  1  one-cycle key strobe; honoured only while `key_ready`=1
- `key_code`  in  5  0x00–0x09 digit, 0x10 ENTER, 0x11 ADD, 0x12 SUB, 0x13 MUL, 0x14 CLEAR, 0x15 DROP; others ignored
- `key_ready`  out  1  high in IDLE only
- `numbers`  out  16  BCD of display value; `[3:0]`=thousands (leftmost char) … `[15:12]`=units
- `err`  out  1  sticky error flag, cleared by CLEAR or reset
- `depth`  out  4  current stack occupancy (0..DEPTH)

One clock; reset is asynchronous and active-high.

## Operation
- Values are unsigned 14-bit, range 0..9999.
- Entry register `entry` + flag `ent_act`. Digit d: if `!ent_act` → entry=d, ent_act=1; else if entry<1000 → entry=entry*10+d; else ignored (4-digit limit, no err).
- ENTER: push `entry` (0 if `!ent_act`), clear ent_act. Stack full → err=1, no change.
- ADD/SUB/MUL: if ent_act, entry counts as top operand (implicitly pushed first). Effective depth <2 → err=1, nothing changes (entry retained). Else pop B (top) and A, push A op B, ent_act=0. Result clamping: sum/product >9999 → 9999, err=1; A−B <0 → 0, err=1. MUL uses full 28-bit product before clamp. Implicit push into a full stack is legal (net depth decreases).
- DROP: ent_act → discard entry; else depth>0 → pop; else err=1.
- CLEAR: depth=0, entry=0, ent_act=0, err=0.
- Unknown code: no state change; conversion pass still runs.
- Display value: entry if ent_act; else top of stack if depth>0; else 0.
- States: IDLE (ready; on key_valid latch code → EXEC), EXEC (one cycle: apply operation, latch display value into converter, counter=0 → CONV), CONV (14 double-dabble iterations: add 3 to each BCD nibble ≥5, then shift left one bit; after iteration 14 load `numbers` → IDLE).
- Stack is a register array indexed by `depth`; no wrap-around, overflow/underflow are err cases above.

## Timing
- Key accepted on edge ending cycle T (key_valid=1, key_ready=1). EXEC = T+1, CONV = T+2..T+15. `numbers` and `key_ready`=1 valid from T+16; `depth`/`err` update visible from T+2.
- key_valid while key_ready=0 is dropped, no err.
- `numbers` holds its previous value throughout EXEC/CONV (no partial BCD visible).
- Reset (any state, async): IDLE, key_ready=1, numbers=16'h0000, err=0, depth=0, entry=0, ent_act=0, stack contents don't-care; in-flight operation aborted.

## Test plan
- Reset, key 1,2,3,4 (each after key_ready) → numbers=16'h4321 (digits "1234"), depth=0; fifth digit 5 → unchanged, err=0.
- 7 ENTER 5 SUB → numbers=16'h2000 ("0002"), depth=1; then 9 SUB → numbers=16'h0000, err=1; CLEAR → err=0, depth=0.
- 9999 ENTER 2 MUL → numbers=16'h9999, err=1; 100 ENTER 99 MUL → numbers=16'h0099 ("9900"), depth=1.
- Push DEPTH values via ENTER, one more ENTER → err=1, depth=DEPTH; ADD with no entry on 1-deep stack → err=1, stack intact.
- Strobe key_valid every cycle after a digit → only keys at key_ready=1 taken; measure key-to-numbers latency = 16 cycles.
- Assert rst during CONV → next cycle numbers=0, key_ready=1, depth=0; subsequent digit 8 → numbers=16'h8000.
